// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared PHY definitions for the serial lane receiver: comma symbol, lock depth
// and the alignment FSM state encoding.
package serial_to_parallel_rx_pkg;

  localparam logic [7:0] COM_BYTE_DEFAULT   = 8'hBC;
  localparam int         LOCK_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_to_parallel_rx_if.sv
// Lane-side bundle of the serial receiver: one serial bit in, recovered bytes out.
interface serial_to_parallel_rx_if;

  // No backpressure: data_out/valid_out hold for a full byte period and
  // byte_strobe marks the single cycle after each locked byte boundary.
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_strobe;

  modport master (
    output data_in,
    input  data_out, valid_out, active, byte_strobe
  );

  modport slave (
    input  data_in,
    output data_out, valid_out, active, byte_strobe
  );

endinterface

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel lane receiver: finds the comma byte, confirms alignment over
// LOCK_COUNT boundaries, then emits payload bytes MSB-first with zero extra latency.
module serial_to_parallel_rx
  import serial_to_parallel_rx_pkg::*;
#(
  parameter logic [7:0] COM_BYTE   = COM_BYTE_DEFAULT,
  parameter int         LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
  input  logic                   clk_4f,
  input  logic                   reset,
  serial_to_parallel_rx_if.slave lane,
  output state_t                 fsm_state
);

  localparam int CW = $clog2(LOCK_COUNT + 1);

  state_t          state, state_next;
  logic [6:0]      shift;
  logic [7:0]      window;
  logic [2:0]      bit_cnt, bit_cnt_next;
  logic [CW-1:0]   com_cnt, com_cnt_next;
  logic [7:0]      data_q, data_next;
  logic            valid_q, valid_next;
  logic            strobe_q, strobe_next;
  logic            boundary;
  logic            is_com;

  // Only the low seven bits of the previous window are ever reused.
  assign window   = {shift, lane.data_in};
  assign is_com   = (window == COM_BYTE);
  assign boundary = (bit_cnt == 3'd7);

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt + 3'd1;
    com_cnt_next = com_cnt;
    data_next    = data_q;
    valid_next   = valid_q;
    strobe_next  = 1'b0;
    case (state)
      SEARCH: begin
        if (is_com) begin
          bit_cnt_next = 3'd0;
          com_cnt_next = CW'(1);
          state_next   = (LOCK_COUNT <= 1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        // Commas at other offsets are ignored here; only SEARCH may realign.
        if (boundary) begin
          if (is_com) begin
            com_cnt_next = com_cnt + CW'(1);
            if ((com_cnt + CW'(1)) == CW'(LOCK_COUNT)) state_next = ACTIVE;
          end else begin
            com_cnt_next = '0;
            state_next   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          strobe_next = 1'b1;
          if (is_com) begin
            valid_next = 1'b0;
          end else begin
            data_next  = window;
            valid_next = 1'b1;
          end
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      shift    <= '0;
      bit_cnt  <= '0;
      com_cnt  <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_next;
      shift    <= window[6:0];
      bit_cnt  <= bit_cnt_next;
      com_cnt  <= com_cnt_next;
      data_q   <= data_next;
      valid_q  <= valid_next;
      strobe_q <= strobe_next;
    end
  end

  assign lane.data_out    = data_q;
  assign lane.valid_out   = valid_q;
  assign lane.byte_strobe = strobe_q;
  assign lane.active      = (state == ACTIVE);
  assign fsm_state        = state;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for the serial lane receiver: reset, comma alignment, aborted
// alignment, payload/comma interleave, mid-byte reset and a comma-free stream.
module tb_serial_to_parallel_rx;
  import serial_to_parallel_rx_pkg::*;

  logic       clk_4f = 1'b0;
  logic       reset  = 1'b0;
  state_t     fsm_state;
  int         total  = 0;
  int         passed = 0;
  int         failed = 0;
  int         strobe_seen = 0;
  logic [7:0] exp_q[$];

  serial_to_parallel_rx_if lane();

  serial_to_parallel_rx dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .lane      (lane),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk_4f = ~clk_4f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: input changes on the falling edge, outputs sampled 1ns after the rising edge
  task automatic send_bit(input logic b);
    @(negedge clk_4f);
    lane.data_in = b;
    @(posedge clk_4f);
    #1;
    if (lane.byte_strobe) strobe_seen++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    strobe_seen = 0;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_data"},   32'(lane.data_out),    32'h00);
    check({tag, "_valid"},  32'(lane.valid_out),   32'h0);
    check({tag, "_active"}, 32'(lane.active),      32'h0);
    check({tag, "_strobe"}, 32'(lane.byte_strobe), 32'h0);
    check({tag, "_state"},  32'(fsm_state),        32'(SEARCH));
  endtask

  task automatic lock_up(input string tag);
    send_byte(8'hBC);
    check({tag, "_bc1_state"}, 32'(fsm_state),      32'(ALIGN));
    check({tag, "_bc1_data"},  32'(lane.data_out),  32'h00);
    check({tag, "_bc1_valid"}, 32'(lane.valid_out), 32'h0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    check({tag, "_bc3_active"}, 32'(lane.active), 32'h0);
    send_byte(8'hBC);
    check({tag, "_bc4_active"}, 32'(lane.active),      32'h1);
    check({tag, "_bc4_strobe"}, 32'(lane.byte_strobe), 32'h0);
    check({tag, "_bc4_valid"},  32'(lane.valid_out),   32'h0);
  endtask

  // scoreboard: payload bytes are queued as sent and compared when they land
  task automatic send_payload(input string tag, input logic [7:0] b);
    logic [7:0] exp;
    exp_q.push_back(b);
    send_byte(b);
    exp = exp_q.pop_front();
    check({tag, "_data"},    32'(lane.data_out),    32'(exp));
    check({tag, "_valid"},   32'(lane.valid_out),   32'h1);
    check({tag, "_strobe"},  32'(lane.byte_strobe), 32'h1);
    check({tag, "_strobes"}, 32'(strobe_seen),      32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    repeat (3) @(negedge clk_4f);
    lane.data_in = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] hist;
    logic       b;
    logic       any_active;
    logic       any_valid;

    // reset held low with the lane toggling
    lane.data_in = 1'b0;
    repeat (5) begin
      @(negedge clk_4f);
      lane.data_in = ~lane.data_in;
    end
    check_outputs_clear("reset_hold");
    lane.data_in = 1'b0;
    reset = 1'b1;

    // comma-free random stream, including across every 8-bit window
    hist = 8'h00;
    any_active = 1'b0;
    any_valid  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      b = 1'($urandom_range(0, 1));
      if ({hist[6:0], b} == 8'hBC) b = ~b;
      hist = {hist[6:0], b};
      send_bit(b);
      if (lane.active !== 1'b0) any_active = 1'b1;
      if (lane.valid_out !== 1'b0) any_valid = 1'b1;
    end
    check("nobc_active", 32'(any_active), 32'h0);
    check("nobc_valid",  32'(any_valid),  32'h0);
    check("nobc_state",  32'(fsm_state),  32'(SEARCH));

    // lock from bit offset 3, then two payload bytes
    pulse_reset();
    repeat (3) send_bit(1'b0);
    lock_up("off3");
    send_payload("ff", 8'hFF);
    send_payload("ee", 8'hEE);

    // payload, comma, payload while locked
    send_payload("p03", 8'h03);
    send_byte(8'hBC);
    check("com_valid",  32'(lane.valid_out),   32'h0);
    check("com_data",   32'(lane.data_out),    32'h03);
    check("com_strobe", 32'(lane.byte_strobe), 32'h1);
    check("com_active", 32'(lane.active),      32'h1);
    send_payload("p04", 8'h04);

    // reset four bits into a byte while locked
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b0;
    #1;
    check_outputs_clear("midbyte_rst");
    repeat (3) @(negedge clk_4f);
    lane.data_in = 1'b0;
    reset = 1'b1;
    lock_up("relock");
    send_payload("aa", 8'hAA);

    // alignment aborted by a non-comma boundary, then a clean lock
    pulse_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    check("abort_align", 32'(fsm_state), 32'(ALIGN));
    send_byte(8'h55);
    check("abort_state",  32'(fsm_state),   32'(SEARCH));
    check("abort_active", 32'(lane.active), 32'h0);
    lock_up("second");
    send_payload("dd", 8'hDD);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
